// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor: counts prescaled PLL clock edges per clk_50m window and flags out-of-tolerance clocks
`timescale 1ns/1ps
module clk_freq_monitor #(
    parameter int WIN_CYC    = 50000,
    parameter int EXP_100M   = 12500,
    parameter int EXP_12P5M  = 1562,
    parameter int EXP_10M    = 1250,
    parameter int TOL        = 4,
    parameter int FAIL_LIMIT = 2,
    parameter int SETTLE_WIN = 2
) (
    input  logic        clk_50m,
    input  logic        w_sys_rst_n,
    input  logic        clk_100m_in,
    input  logic        clk_12p5m_in,
    input  logic        clk_10m_in,
    input  logic        mon_en,
    input  logic        fault_clr,
    output logic [2:0]  clk_ok,
    output logic [2:0]  clk_fault,
    output logic        all_ok,
    output logic        meas_valid,
    output logic [15:0] cnt_100m,
    output logic [15:0] cnt_12p5m,
    output logic [15:0] cnt_10m
);
    localparam int WW = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam logic [WW-1:0] WIN_LAST = WW'(WIN_CYC - 1);
    localparam logic [7:0] SETTLE_N = 8'(SETTLE_WIN);
    localparam logic [3:0] FAIL_N = 4'(FAIL_LIMIT);
    localparam int EXP_TBL [3] = '{EXP_10M, EXP_12P5M, EXP_100M};

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, EVAL} state_t;
    state_t state, state_nxt;

    logic [2:0] mclk;
    logic [2:0][15:0] cnt_all;
    logic [WW-1:0] win_cnt;
    logic [7:0] settle_cnt;
    logic counting, term, publish, eval;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic r);
        return (r && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    assign mclk = {clk_100m_in, clk_12p5m_in, clk_10m_in};
    assign term = win_cnt == WIN_LAST;
    assign counting = mon_en && (state == SETTLE || state == MEASURE);
    assign publish = mon_en && state == MEASURE && term;
    assign eval = mon_en && state == EVAL;
    assign meas_valid = state == EVAL;
    assign all_ok = &clk_ok;
    assign cnt_100m = cnt_all[2];
    assign cnt_12p5m = cnt_all[1];
    assign cnt_10m = cnt_all[0];

    always_ff @(posedge clk_50m or negedge w_sys_rst_n)
        if (!w_sys_rst_n) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (SETTLE_WIN == 0) ? MEASURE : SETTLE;
            SETTLE:  if (term && settle_cnt <= 8'd1) state_nxt = MEASURE;
            MEASURE: if (term) state_nxt = EVAL;
            default: state_nxt = MEASURE;
        endcase
        if (!mon_en) state_nxt = IDLE;
    end

    always_ff @(posedge clk_50m or negedge w_sys_rst_n)
        if (!w_sys_rst_n) begin
            win_cnt <= '0;
            settle_cnt <= '0;
        end else begin
            win_cnt <= (!counting || term) ? '0 : win_cnt + WW'(1);
            settle_cnt <= (state == IDLE) ? SETTLE_N : (state == SETTLE && term) ? settle_cnt - 8'd1 : settle_cnt;
        end

    for (genvar i = 0; i < 3; i++) begin : g_clk
        logic [2:0] ps, sy;
        logic [15:0] edges, cnt;
        logic [3:0] bad, bad_inc;
        logic ok, ok_nxt, flt, rise, good;

        // free-running divide-by-8 in the monitored domain; only its MSB crosses over
        always_ff @(posedge mclk[i] or negedge w_sys_rst_n)
            if (!w_sys_rst_n) ps <= '0;
            else ps <= ps + 3'd1;

        assign rise = sy[1] & ~sy[2];
        assign good = cnt != 16'd0 && cnt != 16'hFFFF &&
                      $signed({16'd0, cnt}) >= EXP_TBL[i] - TOL &&
                      $signed({16'd0, cnt}) <= EXP_TBL[i] + TOL;
        assign bad_inc = (bad == 4'hF) ? bad : bad + 4'd1;
        assign ok_nxt = !eval ? ok : good ? 1'b1 : (bad_inc >= FAIL_N) ? 1'b0 : ok;

        always_ff @(posedge clk_50m or negedge w_sys_rst_n)
            if (!w_sys_rst_n) begin
                sy <= '0;
                edges <= '0;
                cnt <= '0;
                bad <= '0;
                ok <= 1'b0;
                flt <= 1'b0;
            end else begin
                sy <= {sy[1:0], ps[2]};
                edges <= (!counting || term) ? 16'd0 : sat_inc(edges, rise);
                if (publish) cnt <= sat_inc(edges, rise);
                bad <= (!mon_en || (eval && good)) ? 4'd0 : eval ? bad_inc : bad;
                ok <= ok_nxt;
                flt <= (flt & ~fault_clr) | (ok & ~ok_nxt);
            end

        assign clk_ok[i] = ok;
        assign clk_fault[i] = flt;
        assign cnt_all[i] = cnt;
    end
endmodule
